// File: rtl/relu_grad_serializer.sv
// Purpose : capture a WIDTH-word gradient vector and stream it out LANES words per beat.
// Latency : first beat valid 1 cycle after capture; one beat per cycle while out_ready=1.
// Backpr. : out_ready=0 freezes all outputs; in_ready stays low until the last beat is accepted.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_vec/in_valid     full gradient vector offered by the ReLU backward stage
//   in_ready            vector is captured this cycle when in_valid is also high
//   out_data/out_valid  current beat (lane k = element out_idx*LANES+k)
//   out_ready           consumer accepts the beat when high together with out_valid
//   out_idx/out_last    beat index within the vector, high on the final beat
//   vec_count           vectors fully emitted since reset (wraps at 16 bits)
module relu_grad_serializer #(
    parameter  int WIDTH = 1024,
    parameter  int LANES = 8,
    localparam int BEATS = WIDTH / LANES,
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   in_vec [WIDTH-1:0],
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   out_data [LANES-1:0],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic [15:0]   vec_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);

    state_t          state_q,     state_d;
    logic [IW-1:0]   beat_q,      beat_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q,  out_last_d;
    logic [15:0]     vec_count_q, vec_count_d;
    logic [31:0]     out_data_q  [LANES-1:0];
    logic [31:0]     out_data_d  [LANES-1:0];
    logic [31:0]     buf_q       [WIDTH-1:0];
    logic [31:0]     buf_d       [WIDTH-1:0];

    logic            fire;
    logic            last_fire;
    logic            capture;
    logic [IW-1:0]   next_beat;
    logic [AW-1:0]   rd_idx;

    // Handshake decode. in_ready is combinational on out_ready so a new vector
    // can be captured on the same edge that retires the last beat (no bubble).
    always_comb begin
        fire      = (state_q == ST_SEND) && out_valid_q && out_ready;
        last_fire = fire && out_last_q;
        in_ready  = (state_q == ST_IDLE) || last_fire;
        capture   = in_valid && in_ready;
        next_beat = beat_q + IW'(1);
    end

    // Capture buffer: in_vec is only looked at on the capture edge, so the
    // producer is free to change it while the vector is being streamed.
    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            buf_d[j] = capture ? in_vec[j] : buf_q[j];
        end
    end

    // Next-state and registered-output logic. out_data is registered, so the
    // slice for the *next* beat is selected here from the buffer (or straight
    // from in_vec when a vector is being captured this cycle).
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        vec_count_d = vec_count_q + {15'd0, last_fire};
        rd_idx      = '0;
        for (int k = 0; k < LANES; k++) begin
            out_data_d[k] = out_data_q[k];
        end

        if (capture) begin
            state_d     = ST_SEND;
            beat_d      = '0;
            out_valid_d = 1'b1;
            out_last_d  = (BEATS == 1);
            for (int k = 0; k < LANES; k++) begin
                out_data_d[k] = in_vec[k];
            end
        end else if (last_fire) begin
            state_d     = ST_IDLE;
            beat_d      = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                out_data_d[k] = '0;
            end
        end else if (fire) begin
            beat_d     = next_beat;
            out_last_d = (next_beat == LAST_BEAT);
            for (int k = 0; k < LANES; k++) begin
                rd_idx        = AW'(int'(next_beat) * LANES + k);
                out_data_d[k] = buf_q[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            vec_count_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                out_data_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            vec_count_q <= vec_count_d;
            for (int k = 0; k < LANES; k++) begin
                out_data_q[k] <= out_data_d[k];
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        for (int j = 0; j < WIDTH; j++) begin
            buf_q[j] <= buf_d[j];
        end
    end

    always_comb begin
        out_valid = out_valid_q;
        out_idx   = beat_q;
        out_last  = out_last_q;
        vec_count = vec_count_q;
        for (int k = 0; k < LANES; k++) begin
            out_data[k] = out_data_q[k];
        end
    end

endmodule

// File: tb/tb_relu_grad_serializer.sv
module tb_relu_grad_serializer;

    logic clk;
    logic reset;

    // DUT A: WIDTH=16, LANES=4 (4 beats per vector)
    logic [31:0] in_vec_a [15:0];
    logic        in_valid_a;
    logic        in_ready_a;
    logic [31:0] out_data_a [3:0];
    logic        out_valid_a;
    logic        out_ready_a;
    logic [1:0]  out_idx_a;
    logic        out_last_a;
    logic [15:0] vec_count_a;

    // DUT B: WIDTH=LANES=16 (single beat per vector)
    logic [31:0] in_vec_b [15:0];
    logic        in_valid_b;
    logic        in_ready_b;
    logic [31:0] out_data_b [15:0];
    logic        out_valid_b;
    logic        out_ready_b;
    logic [0:0]  out_idx_b;
    logic        out_last_b;
    logic [15:0] vec_count_b;

    int total;
    int bad;

    logic [31:0] exp_vec [15:0];

    relu_grad_serializer #(.WIDTH(16), .LANES(4)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_vec    (in_vec_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_idx   (out_idx_a),
        .out_last  (out_last_a),
        .vec_count (vec_count_a)
    );

    relu_grad_serializer #(.WIDTH(16), .LANES(16)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_vec    (in_vec_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_idx   (out_idx_b),
        .out_last  (out_last_b),
        .vec_count (vec_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1-2 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid_a); end
        total++; if (out_idx_a !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", out_idx_a); end
        total++; if (out_last_a !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b want=0", out_last_a); end
        total++; if (vec_count_a !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", vec_count_a); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready_a); end
        for (int k = 0; k < 4; k++) begin
            total++; if (out_data_a[k] !== 32'h0) begin bad++; $display("FAIL reset_data lane=%0d got=%h want=0", k, out_data_a[k]); end
        end
        total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%0b want=0", out_valid_b); end
    endtask

    // Checks one beat of DUT A against exp_vec; expects out_valid=1.
    task automatic check_beat_a(input string name, input int b, input logic exp_in_ready);
        total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL %s_valid beat=%0d got=%0b want=1", name, b, out_valid_a); end
        total++; if (out_idx_a !== 2'(b)) begin bad++; $display("FAIL %s_idx got=%0d want=%0d", name, out_idx_a, b); end
        total++; if (out_last_a !== (b == 3)) begin bad++; $display("FAIL %s_last beat=%0d got=%0b want=%0b", name, b, out_last_a, (b == 3)); end
        total++; if (in_ready_a !== exp_in_ready) begin bad++; $display("FAIL %s_in_ready beat=%0d got=%0b want=%0b", name, b, in_ready_a, exp_in_ready); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_data_a[k] !== exp_vec[b*4+k]) begin
                bad++; $display("FAIL %s_data beat=%0d lane=%0d got=%h want=%h", name, b, k, out_data_a[k], exp_vec[b*4+k]);
            end
        end
    endtask

    task automatic test_single_vector();
        for (int j = 0; j < 16; j++) begin
            in_vec_a[j] = 32'h3F80_0000 + 32'(j);
            exp_vec[j]  = 32'h3F80_0000 + 32'(j);
        end
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        #1;
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL single_idle_ready got=%0b want=1", in_ready_a); end
        step();
        in_valid_a = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            check_beat_a("single", b, (b == 3));
            step();
            #1;
        end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL single_end_valid got=%0b want=0", out_valid_a); end
        total++; if (vec_count_a !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", vec_count_a); end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        int         exp_b;
        pat   = 7'b1101001;            // applied LSB first: 1,0,0,1,0,1,1
        exp_b = 0;
        in_valid_a  = 1'b1;
        out_ready_a = 1'b0;
        step();
        in_valid_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready_a = pat[i];
            #1;
            check_beat_a("bp", exp_b, pat[i] && (exp_b == 3));
            step();
            if (pat[i]) exp_b++;
        end
        #1;
        total++; if (exp_b !== 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", exp_b); end
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%0b want=0", out_valid_a); end
        total++; if (vec_count_a !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d want=2", vec_count_a); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec_b [15:0];
        for (int j = 0; j < 16; j++) begin
            in_vec_a[j] = 32'(j);
            exp_vec[j]  = 32'(j);
            vec_b[j]    = 32'hBF00_0000 | 32'(j);
        end
        out_ready_a = 1'b1;
        in_valid_a  = 1'b1;
        step();
        in_vec_a = vec_b;              // B offered while A is still streaming
        for (int c = 0; c < 8; c++) begin
            in_valid_a = (c < 4);
            if (c == 4) exp_vec = vec_b;
            #1;
            check_beat_a(c < 4 ? "b2b_a" : "b2b_b", c % 4, (c % 4) == 3);
            step();
        end
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%0b want=0", out_valid_a); end
        total++; if (vec_count_a !== 16'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", vec_count_a); end
    endtask

    task automatic test_input_isolation();
        for (int j = 0; j < 16; j++) begin
            exp_vec[j] = 32'h7FC0_0000 + 32'(j);   // quiet NaN patterns
        end
        exp_vec[0] = 32'h8000_0000;                // -0.0
        exp_vec[1] = 32'h0000_0001;                // smallest denormal
        exp_vec[2] = 32'h7F80_0001;                // signalling NaN
        in_vec_a    = exp_vec;
        in_valid_a  = 1'b1;
        out_ready_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 16; j++) in_vec_a[j] = 32'hFFFF_FFFF;
            #1;
            check_beat_a("iso", b, (b == 3));
            step();
        end
        #1;
        total++; if (vec_count_a !== 16'd5) begin bad++; $display("FAIL iso_count got=%0d want=5", vec_count_a); end
    endtask

    task automatic test_reset_mid_vector();
        for (int j = 0; j < 16; j++) in_vec_a[j] = 32'h1234_0000 + 32'(j);
        in_valid_a  = 1'b1;
        out_ready_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        step();
        step();
        #1;
        total++; if (out_idx_a !== 2'd2) begin bad++; $display("FAIL rst_mid_pre_idx got=%0d want=2", out_idx_a); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b want=0", out_valid_a); end
        total++; if (out_idx_a !== 2'd0) begin bad++; $display("FAIL rst_mid_idx got=%0d want=0", out_idx_a); end
        total++; if (vec_count_a !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d want=0", vec_count_a); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%0b want=1", in_ready_a); end
        step();
        #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_mid_no_partial got=%0b want=0", out_valid_a); end
        for (int j = 0; j < 16; j++) begin
            in_vec_a[j] = 32'h4000_0000 + 32'(j);
            exp_vec[j]  = 32'h4000_0000 + 32'(j);
        end
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        for (int b = 0; b < 4; b++) begin
            #1;
            check_beat_a("rst_fresh", b, (b == 3));
            step();
        end
        #1;
        total++; if (vec_count_a !== 16'd1) begin bad++; $display("FAIL rst_fresh_count got=%0d want=1", vec_count_a); end
    endtask

    task automatic test_single_beat();
        for (int j = 0; j < 16; j++) in_vec_b[j] = 32'hC000_0000 + 32'(j);
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        #1;
        total++; if (out_valid_b !== 1'b1) begin bad++; $display("FAIL sb_valid got=%0b want=1", out_valid_b); end
        total++; if (out_idx_b !== 1'b0) begin bad++; $display("FAIL sb_idx got=%0d want=0", out_idx_b); end
        total++; if (out_last_b !== 1'b1) begin bad++; $display("FAIL sb_last got=%0b want=1", out_last_b); end
        total++; if (in_ready_b !== 1'b1) begin bad++; $display("FAIL sb_in_ready got=%0b want=1", in_ready_b); end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (out_data_b[k] !== 32'hC000_0000 + 32'(k)) begin
                bad++; $display("FAIL sb_data lane=%0d got=%h want=%h", k, out_data_b[k], 32'hC000_0000 + 32'(k));
            end
        end
        step();
        #1;
        total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL sb_end_valid got=%0b want=0", out_valid_b); end
        total++; if (vec_count_b !== 16'd1) begin bad++; $display("FAIL sb_count got=%0d want=1", vec_count_b); end
    endtask

    task automatic test_count_wrap();
        int n;
        n = 0;
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        while (vec_count_b !== 16'hFFFF && n < 70000) begin
            step();
            n++;
        end
        total++; if (vec_count_b !== 16'hFFFF) begin bad++; $display("FAIL wrap_reach got=%0d want=65535 cycles=%0d", vec_count_b, n); end
        total++; if (out_valid_b !== 1'b1) begin bad++; $display("FAIL wrap_pending_valid got=%0b want=1", out_valid_b); end
        in_valid_b = 1'b0;
        step();
        #1;
        total++; if (vec_count_b !== 16'd0) begin bad++; $display("FAIL wrap_count got=%0d want=0", vec_count_b); end
        total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL wrap_end_valid got=%0b want=0", out_valid_b); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b0;
        for (int j = 0; j < 16; j++) begin
            in_vec_a[j] = '0;
            in_vec_b[j] = '0;
            exp_vec[j]  = '0;
        end
        test_reset();
        test_single_vector();
        test_backpressure();
        test_back_to_back();
        test_input_isolation();
        test_reset_mid_vector();
        test_single_beat();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
